// File: rtl/mure_uop_scheduler.sv
// Commit-side uop scheduler for the trace connector.
//
// Collects up to NRET retired-instruction entries per cycle from the commit
// ports, compacts the valid ones in port order into a DEPTH-entry circular
// buffer and presents them one per cycle over a valid/ready handshake. The
// commit path cannot stall, so a cycle whose entries do not all fit is dropped
// whole. The drop sets a sticky overflow flag, bumps a saturating drop counter
// and tags the next written entry as a resync point.
//
// Ports:
//   clk_i       clock, all state on rising edge
//   rst_ni      asynchronous active-low reset
//   uop_i       NRET commit-port entries, uop_i[k].valid qualifies port k
//   flush_i     synchronous flush of buffer, overflow flag and drop counter
//   uop_o       head entry (.valid mirrors valid_o)
//   valid_o     head entry present
//   ready_i     consumer accepts head
//   resync_o    head is the first entry written after a drop
//   count_o     current fill level
//   overflow_o  sticky: at least one drop since reset/flush
//   dropped_o   saturating count of dropped entries

package mure_pkg;

    parameter int unsigned XLEN = 64;

    // XLEN + 7 bits
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [2:0]      itype;
        logic            is_compressed;
        logic [1:0]      priv;
    } uop_entry_s;

endpackage

module mure_uop_scheduler #(
    parameter int unsigned NRET   = 2,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  mure_pkg::uop_entry_s [NRET-1:0] uop_i,
    input  logic                            flush_i,
    output mure_pkg::uop_entry_s            uop_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            resync_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic                            overflow_o,
    output logic [DROP_W-1:0]               dropped_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0]   DepthC  = CntW'(DEPTH);
    localparam logic [CntW-1:0]   CntOne  = CntW'(1);
    localparam logic [PtrW-1:0]   PtrOne  = PtrW'(1);
    localparam logic [DROP_W-1:0] DropMax = '1;

    // Storage
    mure_pkg::uop_entry_s mem_q [DEPTH];
    logic [DEPTH-1:0]     tag_q, tag_d;

    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] dropped_q, dropped_d;
    logic              resync_pend_q, resync_pend_d;

    // Write compaction
    logic [CntW-1:0] n_in;
    logic [CntW-1:0] free_slots;
    logic [PtrW-1:0] wr_idx [NRET];
    logic [NRET-1:0] wr_first;
    logic [NRET-1:0] wr_en;
    logic            accept;
    logic            drop;
    logic            pop;
    logic [DROP_W:0] drop_sum;

    // Each valid port lands at wr_ptr plus the number of valid ports below it,
    // so gaps between ports never occupy a slot.
    always_comb begin
        n_in     = '0;
        wr_first = '0;
        for (int k = 0; k < NRET; k++) begin
            wr_idx[k] = wr_ptr_q + PtrW'(n_in);
            if (uop_i[k].valid) begin
                if (n_in == '0) begin
                    wr_first[k] = 1'b1;
                end
                n_in = n_in + CntOne;
            end
        end
    end

    assign valid_o    = (count_q != '0);
    assign free_slots = DepthC - count_q;

    // Fit is judged against the start-of-cycle count; a same-cycle pop is
    // deliberately not credited so the decision never depends on ready_i.
    assign accept = !flush_i && (n_in != '0) && (n_in <= free_slots);
    assign drop   = !flush_i && (n_in > free_slots);
    assign pop    = !flush_i && valid_o && ready_i;

    always_comb begin
        for (int k = 0; k < NRET; k++) begin
            wr_en[k] = accept && uop_i[k].valid;
        end
    end

    assign drop_sum = {1'b0, dropped_q} + (DROP_W + 1)'(n_in);

    // Next-state
    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        dropped_d     = dropped_q;
        resync_pend_d = resync_pend_q;
        tag_d         = tag_q;

        if (flush_i) begin
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            overflow_d    = 1'b0;
            dropped_d     = '0;
            resync_pend_d = 1'b0;
            tag_d         = '0;
        end else begin
            if (pop) begin
                tag_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = rd_ptr_q + PtrOne;
                count_d         = count_d - CntOne;
            end

            // A write slot never coincides with the popped slot: accepting
            // requires free space, and an empty buffer cannot pop.
            if (accept) begin
                for (int k = 0; k < NRET; k++) begin
                    if (wr_en[k]) begin
                        tag_d[wr_idx[k]] = wr_first[k] & resync_pend_q;
                    end
                end
                wr_ptr_d      = wr_ptr_q + PtrW'(n_in);
                count_d       = count_d + n_in;
                resync_pend_d = 1'b0;
            end

            if (drop) begin
                overflow_d    = 1'b1;
                resync_pend_d = 1'b1;
                dropped_d     = drop_sum[DROP_W] ? DropMax : drop_sum[DROP_W-1:0];
            end
        end
    end

    // Control state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            dropped_q     <= '0;
            resync_pend_q <= 1'b0;
            tag_q         <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            dropped_q     <= dropped_d;
            resync_pend_q <= resync_pend_d;
            tag_q         <= tag_d;
        end
    end

    // Payload storage needs no reset: the output is masked while empty.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NRET; k++) begin
            if (wr_en[k]) begin
                mem_q[wr_idx[k]] <= uop_i[k];
            end
        end
    end

    // Outputs
    always_comb begin
        uop_o = '0;
        if (valid_o) begin
            uop_o       = mem_q[rd_ptr_q];
            uop_o.valid = 1'b1;
        end
    end

    assign resync_o   = valid_o & tag_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign dropped_o  = dropped_q;

endmodule

// File: tb/tb_mure_uop_scheduler.sv
// Self-checking bench for mure_uop_scheduler: a per-cycle vector table for the
// main instance plus hand-written sequences for drop-counter saturation (on a
// small second instance) and asynchronous reset mid-stream.

module tb_mure_uop_scheduler;
    import mure_pkg::*;

    localparam int unsigned NRET   = 2;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DROP_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    uop_entry_s [NRET-1:0] uop_in;
    logic                  flush;
    logic                  ready;
    uop_entry_s            uop_out;
    logic                  valid;
    logic                  resync;
    logic [3:0]            count;
    logic                  overflow;
    logic [DROP_W-1:0]     dropped;

    mure_uop_scheduler #(
        .NRET   (NRET),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .uop_i      (uop_in),
        .flush_i    (flush),
        .uop_o      (uop_out),
        .valid_o    (valid),
        .ready_i    (ready),
        .resync_o   (resync),
        .count_o    (count),
        .overflow_o (overflow),
        .dropped_o  (dropped)
    );

    // Small instance for drop-counter saturation
    uop_entry_s [1:0] s_uop_in;
    logic             s_flush;
    logic             s_ready;
    uop_entry_s       s_uop_out;
    logic             s_valid;
    logic             s_resync;
    logic [1:0]       s_count;
    logic             s_overflow;
    logic [1:0]       s_dropped;

    mure_uop_scheduler #(
        .NRET   (2),
        .DEPTH  (2),
        .DROP_W (2)
    ) dut_small (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .uop_i      (s_uop_in),
        .flush_i    (s_flush),
        .uop_o      (s_uop_out),
        .valid_o    (s_valid),
        .ready_i    (s_ready),
        .resync_o   (s_resync),
        .count_o    (s_count),
        .overflow_o (s_overflow),
        .dropped_o  (s_dropped)
    );

    typedef struct {
        logic        v0;
        logic [63:0] pc0;
        logic        v1;
        logic [63:0] pc1;
        logic        rdy;
        logic        fl;
        logic [3:0]  cnt;
        logic        vld;
        logic [63:0] pc;
        logic        rs;
        logic        ov;
        logic [15:0] drp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Side fields are derived from the pc so pass-through of every field is visible.
    function automatic uop_entry_s ent(input logic v, input logic [63:0] pc);
        uop_entry_s e;
        e.valid         = v;
        e.pc            = pc;
        e.itype         = pc[6:4];
        e.is_compressed = pc[2];
        e.priv          = pc[9:8];
        return e;
    endfunction

    function automatic logic [5:0] meta(input logic [63:0] pc);
        uop_entry_s e;
        e = ent(1'b1, pc);
        return {e.itype, e.is_compressed, e.priv};
    endfunction

    task automatic add(input logic v0, input logic [63:0] pc0, input logic v1,
                       input logic [63:0] pc1, input logic rdy, input logic fl,
                       input logic [3:0] cnt, input logic vld, input logic [63:0] pc,
                       input logic rs, input logic ov, input logic [15:0] drp);
        vec_t r;
        r.v0 = v0; r.pc0 = pc0; r.v1 = v1; r.pc1 = pc1; r.rdy = rdy; r.fl = fl;
        r.cnt = cnt; r.vld = vld; r.pc = pc; r.rs = rs; r.ov = ov; r.drp = drp;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [63:0] pc0, input logic v1,
                         input logic [63:0] pc1, input logic rdy, input logic fl);
        uop_in[0] = ent(v0, pc0);
        uop_in[1] = ent(v1, pc1);
        ready     = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic s_drive(input logic v0, input logic v1);
        s_uop_in[0] = ent(v0, 64'h10);
        s_uop_in[1] = ent(v1, 64'h14);
        @(posedge clk);
        #1;
    endtask

    initial begin
        uop_in   = '0;
        flush    = 1'b0;
        ready    = 1'b0;
        s_uop_in = '0;
        s_flush  = 1'b0;
        s_ready  = 1'b0;

        // Dual write, drain
        add(1, 'h100, 1, 'h104, 1, 0, 2, 1, 'h100, 0, 0, 0);
        add(0, 0,     0, 0,     1, 0, 1, 1, 'h104, 0, 0, 0);
        add(0, 0,     0, 0,     1, 0, 0, 0, 0,     0, 0, 0);
        // Gap compaction: port 1 then port 0
        add(0, 0,     1, 'h200, 1, 0, 1, 1, 'h200, 0, 0, 0);
        add(1, 'h204, 0, 0,     1, 0, 1, 1, 'h204, 0, 0, 0);
        add(0, 0,     0, 0,     1, 0, 0, 0, 0,     0, 0, 0);
        // Fill to 7 with ready low, head held stable
        add(1, 'h010, 1, 'h014, 0, 0, 2, 1, 'h010, 0, 0, 0);
        add(1, 'h018, 1, 'h01c, 0, 0, 4, 1, 'h010, 0, 0, 0);
        add(1, 'h020, 1, 'h024, 0, 0, 6, 1, 'h010, 0, 0, 0);
        add(1, 'h028, 0, 0,     0, 0, 7, 1, 'h010, 0, 0, 0);
        // Pair does not fit in 1 free slot: both dropped
        add(1, 'h300, 1, 'h304, 0, 0, 7, 1, 'h010, 0, 1, 2);
        // Next write accepted and tagged
        add(1, 'h308, 0, 0,     0, 0, 8, 1, 'h010, 0, 1, 2);
        // Full with pop: pop happens, writes still dropped
        add(1, 'h400, 1, 'h404, 1, 0, 7, 1, 'h014, 0, 1, 4);
        add(0, 0,     0, 0,     1, 0, 6, 1, 'h018, 0, 1, 4);
        add(0, 0,     0, 0,     1, 0, 5, 1, 'h01c, 0, 1, 4);
        add(0, 0,     0, 0,     1, 0, 4, 1, 'h020, 0, 1, 4);
        add(0, 0,     0, 0,     1, 0, 3, 1, 'h024, 0, 1, 4);
        add(0, 0,     0, 0,     1, 0, 2, 1, 'h028, 0, 1, 4);
        add(0, 0,     0, 0,     1, 0, 1, 1, 'h308, 1, 1, 4);
        add(0, 0,     0, 0,     1, 0, 0, 0, 0,     0, 1, 4);
        // Flush with a same-cycle write
        add(1, 'h500, 1, 'h504, 1, 1, 0, 0, 0,     0, 0, 0);
        add(0, 0,     0, 0,     1, 0, 0, 0, 0,     0, 0, 0);
        // Streaming 2 in / 1 out, straddles the wrap, then drops
        add(1, 'h5fc, 0, 0,     1, 0, 1, 1, 'h5fc, 0, 0, 0);
        add(1, 'h600, 1, 'h604, 1, 0, 2, 1, 'h600, 0, 0, 0);
        add(1, 'h608, 1, 'h60c, 1, 0, 3, 1, 'h604, 0, 0, 0);
        add(1, 'h610, 1, 'h614, 1, 0, 4, 1, 'h608, 0, 0, 0);
        add(1, 'h618, 1, 'h61c, 1, 0, 5, 1, 'h60c, 0, 0, 0);
        add(1, 'h620, 1, 'h624, 1, 0, 6, 1, 'h610, 0, 0, 0);
        add(1, 'h628, 1, 'h62c, 1, 0, 7, 1, 'h614, 0, 0, 0);
        add(1, 'h630, 1, 'h634, 1, 0, 6, 1, 'h618, 0, 1, 2);
        add(1, 'h638, 1, 'h63c, 1, 0, 7, 1, 'h61c, 0, 1, 2);
        add(0, 0,     0, 0,     1, 0, 6, 1, 'h620, 0, 1, 2);
        add(0, 0,     0, 0,     1, 0, 5, 1, 'h624, 0, 1, 2);
        add(0, 0,     0, 0,     1, 0, 4, 1, 'h628, 0, 1, 2);
        add(0, 0,     0, 0,     1, 0, 3, 1, 'h62c, 0, 1, 2);
        add(0, 0,     0, 0,     1, 0, 2, 1, 'h638, 1, 1, 2);
        add(0, 0,     0, 0,     1, 0, 1, 1, 'h63c, 0, 1, 2);
        add(0, 0,     0, 0,     1, 0, 0, 0, 0,     0, 1, 2);

        // Reset state
        #12;
        chk("reset count", 64'(count), 0);
        chk("reset valid", 64'(valid), 0);
        chk("reset uop", 64'(uop_out.pc), 0);
        chk("reset uop meta", 64'({uop_out.valid, uop_out.itype, uop_out.is_compressed,
                                   uop_out.priv}), 0);
        chk("reset resync", 64'(resync), 0);
        chk("reset overflow", 64'(overflow), 0);
        chk("reset dropped", 64'(dropped), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].v0, vecs[i].pc0, vecs[i].v1, vecs[i].pc1, vecs[i].rdy, vecs[i].fl);
            chk($sformatf("row%0d count", i), 64'(count), 64'(vecs[i].cnt));
            chk($sformatf("row%0d valid", i), 64'(valid), 64'(vecs[i].vld));
            chk($sformatf("row%0d uop.valid", i), 64'(uop_out.valid), 64'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk($sformatf("row%0d pc", i), uop_out.pc, vecs[i].pc);
                chk($sformatf("row%0d meta", i),
                    64'({uop_out.itype, uop_out.is_compressed, uop_out.priv}),
                    64'(meta(vecs[i].pc)));
            end
            chk($sformatf("row%0d resync", i), 64'(resync), 64'(vecs[i].rs));
            chk($sformatf("row%0d overflow", i), 64'(overflow), 64'(vecs[i].ov));
            chk($sformatf("row%0d dropped", i), 64'(dropped), 64'(vecs[i].drp));
        end
        uop_in = '0;
        ready  = 1'b0;

        // Saturating drop counter on the 2-deep, 2-bit instance
        s_drive(1, 1);
        chk("sat fill count", 64'(s_count), 2);
        s_drive(1, 1);
        chk("sat drop1 dropped", 64'(s_dropped), 2);
        chk("sat drop1 overflow", 64'(s_overflow), 1);
        s_drive(1, 1);
        chk("sat drop2 dropped", 64'(s_dropped), 3);
        s_drive(1, 0);
        chk("sat drop3 dropped", 64'(s_dropped), 3);
        chk("sat count held", 64'(s_count), 2);
        s_uop_in = '0;

        // Fill, drop (resync pending), then async reset mid-cycle
        drive(1, 'h700, 1, 'h704, 0, 0);
        drive(1, 'h708, 1, 'h70c, 0, 0);
        drive(1, 'h710, 1, 'h714, 0, 0);
        drive(1, 'h718, 1, 'h71c, 0, 0);
        drive(1, 'h720, 0, 0, 0, 0);
        chk("pre-reset count", 64'(count), 8);
        chk("pre-reset dropped", 64'(dropped), 3);
        uop_in = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async count", 64'(count), 0);
        chk("async valid", 64'(valid), 0);
        chk("async uop", 64'(uop_out.pc), 0);
        chk("async resync", 64'(resync), 0);
        chk("async overflow", 64'(overflow), 0);
        chk("async dropped", 64'(dropped), 0);
        chk("async small dropped", 64'(s_dropped), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Reset also cleared the pending resync: no tag on the next write
        drive(1, 'h740, 0, 0, 0, 0);
        chk("post-reset count", 64'(count), 1);
        chk("post-reset pc", uop_out.pc, 64'h740);
        chk("post-reset resync", 64'(resync), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
